// File: rtl/result_tx_framer_pkg.sv
// result_tx_framer_pkg: shared types, sizes and framing constants for the result TX framer.
package result_tx_framer_pkg;
  localparam int RES_W = 20;
  localparam int MAX_N = 8;
  localparam int DATA_W = RES_W * MAX_N;
  localparam logic [7:0] HDR_BYTE = 8'hFE;
  localparam logic [7:0] TRL_BYTE = 8'hEF;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, FIN} tx_state_t;
  // Index of the trailer byte, which is also the last byte of a frame of nc results.
  function automatic logic [4:0] last_idx(input logic [3:0] nc);
    return 5'(3 * nc + 2);
  endfunction
endpackage

// File: rtl/result_tx_framer_if.sv
// result_tx_framer_if: result capture and UART TX byte handshake bundle.
interface result_tx_framer_if;
  import result_tx_framer_pkg::*;
  logic START;
  logic [3:0] MAT_SIZE;
  logic [DATA_W-1:0] DATA_IN;
  logic TX_READY;
  logic [7:0] TX_DATA;
  logic TX_SEND;
  logic BUSY;
  logic DONE;
  modport master (output START, MAT_SIZE, DATA_IN, TX_READY, input TX_DATA, TX_SEND, BUSY, DONE);
  modport slave (input START, MAT_SIZE, DATA_IN, TX_READY, output TX_DATA, TX_SEND, BUSY, DONE);
endinterface

// File: rtl/result_tx_framer_result_byte_mux.sv
// result_byte_mux: selects header, count, result or trailer byte for the current frame position.
module result_byte_mux
  import result_tx_framer_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [3:0]        nc_i,
  input  logic [4:0]        cnt_i,
  output logic [7:0]        byte_o
);
  logic [RES_W-1:0] res [MAX_N];
  logic [RES_W-1:0] r;
  logic [4:0] idx, k, j;
  for (genvar g = 0; g < MAX_N; g++) begin : g_res
    assign res[g] = data_i[(MAX_N-1-g)*RES_W +: RES_W];
  end
  always_comb begin
    idx = cnt_i - 5'd2;
    k = idx / 5'd3;
    j = idx % 5'd3;
    r = '0;
    for (int i = 0; i < MAX_N; i++) if (k == 5'(i)) r = res[i];
    byte_o = cnt_i == 5'd0 ? HDR_BYTE :
             cnt_i == 5'd1 ? {4'h0, nc_i} :
             cnt_i == last_idx(nc_i) ? TRL_BYTE :
             j == 5'd0 ? {4'h0, r[19:16]} :
             j == 5'd1 ? r[15:8] : r[7:0];
  end
endmodule

// File: rtl/result_tx_framer.sv
// result_tx_framer: latches a result vector and streams it as a framed byte sequence to a UART TX.
module result_tx_framer
  import result_tx_framer_pkg::*;
(
  input logic clk,
  input logic rst,
  result_tx_framer_if.slave bus
);
  tx_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [3:0] nc_q, nc_d;
  logic [7:0] tx_data_q, tx_data_d, cur_byte;
  logic send;
  result_byte_mux u_mux (.data_i(shadow_q), .nc_i(nc_q), .cnt_i(cnt_q), .byte_o(cur_byte));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shadow_d = shadow_q;
    nc_d = nc_q;
    send = 1'b0;
    case (state_q)
      IDLE: if (bus.START) begin
        state_d = SEND;
        cnt_d = '0;
        shadow_d = bus.DATA_IN;
        nc_d = bus.MAT_SIZE > 4'(MAX_N) ? 4'(MAX_N) : bus.MAT_SIZE;
      end
      SEND: if (bus.TX_READY) begin
        send = 1'b1;
        state_d = WAIT_LO;
      end
      WAIT_LO: if (!bus.TX_READY) state_d = WAIT_HI;
      WAIT_HI: if (bus.TX_READY) begin
        state_d = cnt_q == last_idx(nc_q) ? FIN : SEND;
        cnt_d = cnt_q == last_idx(nc_q) ? cnt_q : cnt_q + 5'd1;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_data_d = send ? cur_byte : tx_data_q;
  end
  // TX_DATA is presented in the strobe cycle itself and then held in tx_data_q.
  assign bus.TX_DATA = tx_data_d;
  assign bus.TX_SEND = send;
  assign bus.BUSY = state_q == SEND || state_q == WAIT_LO || state_q == WAIT_HI;
  assign bus.DONE = state_q == FIN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shadow_q <= '0;
      nc_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      nc_q <= nc_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_result_tx_framer.sv
// tb_result_tx_framer: directed checks of framing, shadowing, reset abort and TX_READY stalls.
module tb_result_tx_framer;
  logic clk = 1'b0;
  logic rst;
  logic hold = 1'b0;
  logic in_frame = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] got[$];
  int done_cnt = 0;
  int gap = 0;
  int rdy_n = 0;
  logic sent;
  result_tx_framer_if bus();
  result_tx_framer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // UART model: sees a strobe, drops ready after the next edge, stays busy 4 cycles.
  initial begin
    bus.TX_READY = 1'b1;
    forever begin
      @(negedge clk);
      sent = bus.TX_SEND;
      if (sent) got.push_back(bus.TX_DATA);
      if (bus.DONE) done_cnt++;
      if (in_frame && !bus.BUSY && !bus.DONE) gap++;
      @(posedge clk);
      #1;
      rdy_n = sent ? 4 : (rdy_n > 0 ? rdy_n - 1 : 0);
      bus.TX_READY = (rdy_n == 0) && !hold;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_frame(input logic [3:0] n, input logic [159:0] d);
    @(posedge clk);
    #1;
    bus.MAT_SIZE = n;
    bus.DATA_IN = d;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    in_frame = 1'b1;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.DONE) break;
    end
    in_frame = 1'b0;
    repeat (20) @(negedge clk);
  endtask
  task automatic check_frame(input string tag, input int base, input int d0, input logic [7:0] e[$]);
    chk({tag, "_len"}, got.size() - base, e.size());
    for (int i = 0; i < e.size(); i++) chk({tag, "_byte"}, got[base+i], e[i]);
    chk({tag, "_done"}, done_cnt - d0, 1);
  endtask
  initial begin
    logic [7:0] e[$];
    int base, d0, n4, hold_sends;
    rst = 1'b1;
    bus.START = 1'b0;
    bus.MAT_SIZE = '0;
    bus.DATA_IN = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx_data", bus.TX_DATA, 8'h00);
    chk("rst_tx_send", bus.TX_SEND, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Two results, MSB-first byte split.
    base = got.size(); d0 = done_cnt;
    start_frame(4'd2, {20'hABCDE, 20'h01234, 120'h0});
    chk("t1_busy", bus.BUSY, 1'b1);
    wait_done();
    e = '{8'hFE, 8'h02, 8'h0A, 8'hBC, 8'hDE, 8'h00, 8'h12, 8'h34, 8'hEF};
    check_frame("t1", base, d0, e);
    chk("t1_hold_data", bus.TX_DATA, 8'hEF);
    chk("t1_idle_busy", bus.BUSY, 1'b0);
    // Empty frame.
    base = got.size(); d0 = done_cnt;
    start_frame(4'd0, {160{1'b1}});
    wait_done();
    e = '{8'hFE, 8'h00, 8'hEF};
    check_frame("t2", base, d0, e);
    // Oversized count is clipped to eight results.
    base = got.size(); d0 = done_cnt;
    start_frame(4'd12, {160{1'b1}});
    wait_done();
    e = '{8'hFE, 8'h08};
    for (int i = 0; i < 8; i++) begin
      e.push_back(8'h0F);
      e.push_back(8'hFF);
      e.push_back(8'hFF);
    end
    e.push_back(8'hEF);
    check_frame("t3", base, d0, e);
    // Mid-frame data change and second START are ignored.
    base = got.size(); d0 = done_cnt; gap = 0;
    start_frame(4'd1, {20'h12345, 140'h0});
    repeat (10) @(posedge clk);
    #1;
    bus.DATA_IN = {20'h55555, 20'hAAAAA, 120'h0};
    bus.MAT_SIZE = 4'd3;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    wait_done();
    e = '{8'hFE, 8'h01, 8'h01, 8'h23, 8'h45, 8'hEF};
    check_frame("t4", base, d0, e);
    chk("t4_busy_gap", gap, 0);
    // Async reset after the fourth strobe aborts the frame.
    base = got.size(); n4 = 0;
    start_frame(4'd2, {20'hABCDE, 20'h01234, 120'h0});
    for (int i = 0; i < 400 && n4 < 4; i++) begin
      @(negedge clk);
      if (bus.TX_SEND) n4++;
    end
    chk("t5_four_sent", n4, 4);
    #1;
    rst = 1'b1;
    in_frame = 1'b0;
    #1;
    chk("t5_rst_send", bus.TX_SEND, 1'b0);
    chk("t5_rst_busy", bus.BUSY, 1'b0);
    chk("t5_rst_done", bus.DONE, 1'b0);
    chk("t5_rst_data", bus.TX_DATA, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = got.size();
    repeat (40) @(negedge clk);
    chk("t5_no_strobes", got.size() - base, 0);
    d0 = done_cnt;
    start_frame(4'd1, {20'h9ABCD, 140'h0});
    wait_done();
    e = '{8'hFE, 8'h01, 8'h09, 8'hAB, 8'hCD, 8'hEF};
    check_frame("t5", base, d0, e);
    // TX_READY stalled low at START.
    @(negedge clk);
    hold = 1'b1;
    base = got.size(); d0 = done_cnt; hold_sends = 0;
    start_frame(4'd1, {20'h00077, 140'h0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.TX_SEND) hold_sends++;
    end
    chk("t6_no_send", hold_sends, 0);
    chk("t6_busy", bus.BUSY, 1'b1);
    hold = 1'b0;
    @(negedge clk);
    chk("t6_first_send", bus.TX_SEND, 1'b1);
    chk("t6_first_byte", bus.TX_DATA, 8'hFE);
    wait_done();
    e = '{8'hFE, 8'h01, 8'h00, 8'h00, 8'h77, 8'hEF};
    check_frame("t6", base, d0, e);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_tx_framer.md
Name: result_tx_framer

Overview:
- Transmit-side counterpart of the matrix-vector processor's result bus.
- Captures the 160-bit packed result vector (up to 8 results of 20 bits) plus the matrix size.
- Serializes them as a framed byte stream into the UART transmitter through a ready/send handshake.
- Sits between the processor's DATA_OUT/OP_DONE and the UART TX byte interface.

Parameters:
- RES_W, 20, width of one result word
- MAX_N, 8, maximum number of results per frame (DATA_IN width = RES_W*MAX_N)
- HDR_BYTE, 8'hFE, frame header byte
- TRL_BYTE, 8'hEF, frame trailer byte

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- START  input  1  one-cycle request to send a frame; sampled only in IDLE
- MAT_SIZE  input  4  number of valid results N, sampled with START
- DATA_IN  input  160  packed results; result k at DATA_IN[159-20k -: 20], k=0 sent first
- TX_READY  input  1  UART transmitter idle, able to accept a byte
- TX_DATA  output  8  byte to transmit, valid while TX_SEND=1
- TX_SEND  output  1  one-cycle strobe: UART loads TX_DATA
- BUSY  output  1  frame in progress
- DONE  output  1  one-cycle pulse when the final byte has been accepted and completed

Behaviour:
- Reset values: TX_DATA=8'h00, TX_SEND=0, BUSY=0, DONE=0, state=IDLE, byte counter=0, shadow register=0.
- Async reset mid-frame aborts immediately. No further TX_SEND is issued until a new START.
- Frame format: HDR_BYTE, count byte {4'h0,Nc}, then 3 bytes per result, then TRL_BYTE. Total 3+3*Nc bytes.
- Nc = min(MAT_SIZE, MAX_N). MAT_SIZE=0 is legal and sends header, 0x00, trailer.
- Result byte order is MSB first: {4'h0, r[19:16]}, r[15:8], r[7:0].
- START in IDLE: DATA_IN and Nc are latched into a shadow register in the same edge; BUSY=1 from the next cycle.
- Later changes to DATA_IN or MAT_SIZE do not affect the frame in progress.
- START while BUSY=1 is ignored; it is not queued.
- States:
  - IDLE: wait for START.
  - SEND: if TX_READY=1, drive TX_DATA and pulse TX_SEND for 1 cycle, then go to WAIT_LO; else stay in SEND.
  - WAIT_LO: wait for TX_READY=0, the UART acknowledging the byte.
  - WAIT_HI: wait for TX_READY=1. On entry, if the byte just sent was the last, go to FIN; else increment the byte counter and go to SEND.
  - FIN: DONE=1 and BUSY=0 for one cycle, then IDLE.
- Latency: the first TX_SEND occurs in the cycle after START if TX_READY=1.
- TX_DATA holds its last value outside SEND strobes. Only TX_SEND qualifies TX_DATA.
- The byte counter is 5 bits, range 0..26. It never wraps; it is cleared on START.
- Exactly one TX_SEND per byte.

Decomposition:
- Definitions_Package additions:
  - tx_state_t enum (IDLE, SEND, WAIT_LO, WAIT_HI, FIN)
  - HDR_BYTE and TRL_BYTE constants
  - RES_W and MAX_N constants
- One combinational sub-module, result_byte_mux.
  - Inputs: shadow register, Nc, byte counter.
  - Output: the current frame byte (header, count, result byte, or trailer).
- result_tx_framer holds the FSM, counter, shadow register and handshake.

Test Plan:
1. UART model: drops TX_READY 1 cycle after TX_SEND, busy 4 cycles. MAT_SIZE=2, DATA_IN[159:140]=20'hABCDE, [139:120]=20'h01234, START -> bytes FE 02 0A BC DE 00 12 34 EF; 9 TX_SEND pulses; exactly one DONE.
2. MAT_SIZE=0, START -> bytes FE 00 EF; DONE after the third byte.
3. MAT_SIZE=12 with all results 20'hFFFFF -> count byte 08, then 24 bytes 0F FF FF repeating, then EF; 27 bytes total.
4. After START, change DATA_IN and pulse START again mid-frame -> frame content unchanged, no second frame, BUSY stays 1 until the single DONE.
5. Assert rst after the 4th TX_SEND -> TX_SEND/BUSY/DONE/TX_DATA become 0 immediately, no more strobes. A new START with MAT_SIZE=1 then sends a complete 6-byte frame.
6. TX_READY held 0 for 10 cycles at START -> no TX_SEND until TX_READY=1, then the first byte FE is sent in that cycle.
